// File: rtl/csr_encoder.sv
// Dense ROWS x COLS matrix to CSR encoder, one element per clock after a start capture edge.
// Latency: done pulses LEN edges after the capture edge; no backpressure, start is ignored while busy.
module csr_encoder #(
  parameter int ROWS        = 3,
  parameter int COLS        = 3,
  parameter int LEN         = ROWS * COLS,
  parameter int DATA_SIZE   = 8,
  parameter int PTR_SIZE    = 4,
  parameter int OFFSET_SIZE = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [LEN*DATA_SIZE-1:0]        Mat_in,
  output logic [(ROWS+1)*PTR_SIZE-1:0]    ptr_out,
  output logic [LEN*OFFSET_SIZE-1:0]      offsets_out,
  output logic [LEN*DATA_SIZE-1:0]        data_out,
  output logic [PTR_SIZE-1:0]             nnz,
  output logic                            busy,
  output logic                            done,
  output logic                            valid
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int EW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state_q;
  logic [DATA_SIZE-1:0]   mat_q  [LEN];
  logic [DATA_SIZE-1:0]   data_q [LEN];
  logic [OFFSET_SIZE-1:0] off_q  [LEN];
  logic [PTR_SIZE-1:0]    ptr_q  [ROWS+1];
  logic [PTR_SIZE-1:0]    nnz_q;
  logic [RW-1:0]          row_q;
  logic [OFFSET_SIZE-1:0] col_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   valid_q;

  logic [EW-1:0]          elem_idx;
  logic [EW-1:0]          wr_idx;
  logic [DATA_SIZE-1:0]   elem;
  logic                   elem_nz;
  logic [PTR_SIZE-1:0]    nnz_d;
  logic                   last_col;
  logic                   last_elem;

  always_comb begin
    elem_idx  = EW'(row_q) * EW'(COLS) + EW'(col_q);
    wr_idx    = EW'(nnz_q);
    elem      = mat_q[elem_idx];
    elem_nz   = |elem;
    nnz_d     = nnz_q + PTR_SIZE'(elem_nz);
    last_col  = (col_q == OFFSET_SIZE'(COLS - 1));
    last_elem = last_col && (row_q == RW'(ROWS - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int e = 0; e < LEN; e++) begin
        mat_q[e]  <= '0;
        data_q[e] <= '0;
        off_q[e]  <= '0;
      end
      for (int r = 0; r <= ROWS; r++) ptr_q[r] <= '0;
      nnz_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Element (0,0) sits at the MSB of Mat_in.
            for (int e = 0; e < LEN; e++) begin
              mat_q[e]  <= Mat_in[(LEN-1-e)*DATA_SIZE +: DATA_SIZE];
              data_q[e] <= '0;
              off_q[e]  <= '0;
            end
            for (int r = 0; r <= ROWS; r++) ptr_q[r] <= '0;
            nnz_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (elem_nz) begin
            data_q[wr_idx] <= elem;
            off_q[wr_idx]  <= col_q;
          end
          nnz_q <= nnz_d;
          if (last_col) begin
            ptr_q[row_q + RW'(1)] <= nnz_d;
            col_q <= '0;
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + OFFSET_SIZE'(1);
          end
          if (last_elem) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  genvar k;
  generate
    for (k = 0; k < LEN; k++) begin : g_slot
      assign data_out[(LEN-k)*DATA_SIZE-1 -: DATA_SIZE]       = data_q[k];
      assign offsets_out[(LEN-k)*OFFSET_SIZE-1 -: OFFSET_SIZE] = off_q[k];
    end
    for (k = 0; k <= ROWS; k++) begin : g_ptr
      assign ptr_out[(ROWS+1-k)*PTR_SIZE-1 -: PTR_SIZE] = ptr_q[k];
    end
  endgenerate

  assign nnz   = nnz_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_csr_encoder.sv
// Directed bench for csr_encoder with hand-computed CSR results for the default 3x3 geometry.
module tb_csr_encoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [71:0] Mat_in;
  logic [15:0] ptr_out;
  logic [17:0] offsets_out;
  logic [71:0] data_out;
  logic [3:0]  nnz;
  logic        busy;
  logic        done;
  logic        valid;

  int checks = 0;
  int errors = 0;

  csr_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .Mat_in      (Mat_in),
    .ptr_out     (ptr_out),
    .offsets_out (offsets_out),
    .data_out    (data_out),
    .nnz         (nnz),
    .busy        (busy),
    .done        (done),
    .valid       (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [71:0] M_S2    = {8'd1, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd3, 8'd4, 8'd0};
  localparam logic [71:0] M_ID    = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
  localparam logic [71:0] M_DENSE = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  localparam logic [71:0] M_EDGE  = {8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
    end while (!done && cyc < 20);
  endtask

  task automatic check_result(input string tag, input logic [15:0] p, input logic [17:0] o,
                              input logic [71:0] d, input logic [3:0] n);
    chk({tag, ".ptr"},   ptr_out, p);
    chk({tag, ".off"},   offsets_out, o);
    chk({tag, ".data"},  data_out, d);
    chk({tag, ".nnz"},   nnz, n);
    chk({tag, ".valid"}, valid, 1'b1);
    chk({tag, ".busy"},  busy, 1'b0);
  endtask

  task automatic run(input logic [71:0] m, input string tag);
    int cyc;
    @(negedge clk);
    Mat_in = m;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, ".busy_scan"}, busy, 1'b1);
    chk({tag, ".valid_clr"}, valid, 1'b0);
    wait_done(cyc);
    chk({tag, ".latency"}, cyc, 9);
    chk({tag, ".done"}, done, 1'b1);
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, ".ptr"},   ptr_out, '0);
    chk({tag, ".off"},   offsets_out, '0);
    chk({tag, ".data"},  data_out, '0);
    chk({tag, ".nnz"},   nnz, '0);
    chk({tag, ".busy"},  busy, 1'b0);
    chk({tag, ".done"},  done, 1'b0);
    chk({tag, ".valid"}, valid, 1'b0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int dcyc;

    reset  = 1'b0;
    start  = 1'b0;
    Mat_in = '0;
    repeat (2) @(posedge clk);
    #1 check_zero_state("reset");
    @(negedge clk) reset = 1'b1;

    run(M_S2, "s2");
    check_result("s2", 16'h0224, {2'd0, 2'd2, 2'd0, 2'd1, 10'd0},
                 {8'd1, 8'd2, 8'd3, 8'd4, 40'd0}, 4'd4);
    @(posedge clk);
    #1 chk("s2.done_pulse", done, 1'b0);
    chk("s2.valid_hold", valid, 1'b1);

    run(M_ID, "id");
    check_result("id", 16'h0123, {2'd0, 2'd1, 2'd2, 12'd0}, {8'd1, 8'd1, 8'd1, 48'd0}, 4'd3);

    run(M_DENSE, "dense");
    check_result("dense", 16'h0369, {3{2'd0, 2'd1, 2'd2}}, M_DENSE, 4'd9);

    run('0, "zero");
    check_result("zero", 16'h0000, 18'd0, 72'd0, 4'd0);

    // Extra starts during the scan and a Mat_in change must not disturb the run.
    @(negedge clk);
    Mat_in = M_S2;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; ndone = 0; dcyc = 0;
    repeat (12) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin
        ndone++;
        if (dcyc == 0) dcyc = cyc;
      end
      start = (cyc == 2 || cyc == 4);
      if (cyc == 3) Mat_in = M_DENSE;
    end
    chk("s5.ndone", ndone, 1);
    chk("s5.latency", dcyc, 9);
    check_result("s5", 16'h0224, {2'd0, 2'd2, 2'd0, 2'd1, 10'd0},
                 {8'd1, 8'd2, 8'd3, 8'd4, 40'd0}, 4'd4);

    // Start held high: back-to-back runs, valid drops on the recapture edge.
    @(negedge clk);
    Mat_in = M_EDGE;
    start  = 1'b1;
    @(posedge clk);
    #1 wait_done(cyc);
    chk("b2b.latency1", cyc, 9);
    check_result("b2b1", 16'h0112, {2'd0, 2'd2, 14'd0}, {8'h80, 8'hFF, 56'd0}, 4'd2);
    Mat_in = M_ID;
    @(posedge clk);
    #1 chk("b2b.valid_drop", valid, 1'b0);
    chk("b2b.busy_again", busy, 1'b1);
    start = 1'b0;
    wait_done(cyc);
    chk("b2b.latency2", cyc, 9);
    check_result("b2b2", 16'h0123, {2'd0, 2'd1, 2'd2, 12'd0}, {8'd1, 8'd1, 8'd1, 48'd0}, 4'd3);

    // Asynchronous reset in the middle of a scan discards everything.
    @(negedge clk);
    Mat_in = M_DENSE;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rst.busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1 check_zero_state("rst.async");
    @(posedge clk);
    #1 check_zero_state("rst.held");
    @(negedge clk) reset = 1'b1;
    run(M_ID, "post_rst");
    check_result("post_rst", 16'h0123, {2'd0, 2'd1, 2'd2, 12'd0}, {8'd1, 8'd1, 8'd1, 48'd0}, 4'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_encoder.md
Name: csr_encoder

Overview:
- Converts a dense ROWS x COLS matrix into CSR form: row pointers, column offsets and nonzero data.
- Its output buses use the same widths and packing as the CSR operand inputs of the CSR matmul block, so they connect to it directly.
- Scans one element per clock under a start/done handshake.
- Sits between dense matrix producers and the sparse matmul path.

Parameters:
- ROWS, 3, dense matrix rows.
- COLS, 3, dense matrix columns. Must satisfy COLS <= 2^OFFSET_SIZE.
- LEN, ROWS*COLS, maximum nonzero count; sets the data/offset slot count.
- DATA_SIZE, 8, element width.
- PTR_SIZE, 4, row-pointer width. Must satisfy LEN <= 2^PTR_SIZE-1.
- OFFSET_SIZE, 2, column-offset width.

Ports:
- clk, input, 1: the single clock; all state changes on rising edge.
- reset, input, 1: asynchronous, active-low; clears all state and outputs.
- start, input, 1: request to encode Mat_in. Sampled only in IDLE.
- Mat_in, input, LEN*DATA_SIZE: dense matrix. Element e=r*COLS+c is at bits [(LEN-e)*DATA_SIZE-1 -: DATA_SIZE], so (0,0) is at the MSB.
- ptr_out, output, (ROWS+1)*PTR_SIZE: ptr[r] at bits [(ROWS+1-r)*PTR_SIZE-1 -: PTR_SIZE].
- offsets_out, output, LEN*OFFSET_SIZE: offset[k] at bits [(LEN-k)*OFFSET_SIZE-1 -: OFFSET_SIZE].
- data_out, output, LEN*DATA_SIZE: data[k] at bits [(LEN-k)*DATA_SIZE-1 -: DATA_SIZE].
- nnz, output, PTR_SIZE: number of nonzero elements found.
- busy, output, 1: high while scanning.
- done, output, 1: one-cycle pulse when encoding completes.
- valid, output, 1: high from done until the next accepted start; outputs are stable while high.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All ptr, offset and data slots = 0; nnz=0.
  - busy=0, done=0, valid=0.
  - Row/column counters = 0.
- States: IDLE, SCAN.
- IDLE, start=1 at an edge (capture edge):
  - Register Mat_in into an internal copy. Later Mat_in changes have no effect.
  - Clear all ptr/offset/data slots and nnz.
  - valid<=0, busy<=1, row=col=0, state<=SCAN.
- SCAN, one element (row, col) per edge, in row-major order:
  - If the element is nonzero: data[nnz]<=elem, offset[nnz]<=col, nnz<=nnz+1.
  - If the element is zero: no slot is written.
  - Nonzero test is on all DATA_SIZE bits; the value is raw and carries no sign interpretation.
  - When col==COLS-1: ptr[row+1]<=updated nnz (including the current element), col<=0, row<=row+1. Otherwise col<=col+1.
  - ptr[0] is always 0.
- Completion:
  - On the edge that processes element LEN-1: busy<=0, done<=1 (cleared next edge), valid<=1, state<=IDLE.
  - Latency: done is high in the cycle after the LEN-th SCAN edge, i.e. LEN edges after the capture edge (9 for the defaults).
  - Throughput: a new start is accepted on the edge after done at the earliest (the first IDLE edge).
- Boundaries:
  - Unused data/offset slots (index >= nnz) read 0.
  - All-zero row: ptr[r+1]==ptr[r].
  - All-zero matrix: nnz=0, all ptr=0.
  - Full matrix: nnz=LEN, ptr[ROWS]=LEN; no overflow by parameter constraint.
  - start while busy: ignored, with no effect on the scan in progress.
  - start held high continuously: re-encodes back-to-back. valid pulses high for one cycle between runs, because the next capture edge clears it.
  - reset mid-SCAN: immediate return to the reset state. The partial result is discarded and valid=0.
- Outputs are driven from registers only; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset asserted -> ptr_out=0, offsets_out=0, data_out=0, nnz=0, busy=0, done=0, valid=0.
2. Mat=[[1,0,2],[0,0,0],[3,4,0]], start for one cycle -> done after 9 cycles.
   - ptr_out=16'h0224, nnz=4.
   - data = 1,2,3,4 in slots 0..3; offsets = 0,2,0,1; slots 4..8 = 0.
3. Identity 3x3 -> ptr_out=16'h0123, offsets 0,1,2, data 1,1,1, nnz=3.
   - Then dense [[1..3],[4..6],[7..9]] (values 1 to 9 in row-major order) -> ptr_out=16'h0369, nnz=9, offsets 0,1,2 repeated, data 1..9.
4. All-zero matrix -> ptr_out=0, nnz=0, data_out=0. done and valid still assert after 9 cycles.
5. Use the matrix from scenario 2. Pulse start again at cycles 3 and 5 of the scan, and change Mat_in mid-scan -> exactly one done, 9 cycles after the first start; results match scenario 2.
6. Pull reset low at SCAN cycle 5, release it, then start with the identity matrix -> during reset all outputs are 0 and valid=0. Afterwards the result matches scenario 3 with no residue from the aborted run.
